// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory-port arbiter.
//   - FSM state encoding of the arbiter (IDLE/ISSUE/WAIT/DONE)
//   - owner encoding of the granted requester (fetch or data)
//   - default build constants for memory latency and fetch starvation bound
package cpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_MAX_STREAK = 4;

  // Next value of the data-grant streak counter for a data grant.
  // Counts only while fetch is actually waiting; saturates at max_streak.
  function automatic int next_streak(input int cur, input logic fetch_waiting,
                                     input int max_streak);
    if (!fetch_waiting) return 0;
    if (cur >= max_streak) return max_streak;
    return cur + 1;
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter timing the fixed memory latency.
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-low reset
//   load          - load load_val this cycle (has priority over dec)
//   load_val      - value to load
//   dec           - decrement by one; holds at zero
//   zero          - count is zero
module mem_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between the fetch stage and
// the MEM stage. Data requests win by default; fetch wins when it is the
// only requester or once MAX_STREAK consecutive data grants were taken
// while fetch was waiting.
// Handshake: a requester raises req with a stable command and holds it;
// exactly one ready pulse (with rdata for loads/fetches) ends the access.
// Requests are sampled only while the FSM is IDLE.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   if_req/if_addr                - fetch request and address
//   if_rdata/if_ready/if_stall    - fetch read data, completion pulse, hold
//   d_req/d_we/d_be/d_addr/d_wdata- data request command
//   d_rdata/d_ready/d_stall       - data read data, completion pulse, hold
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata - memory command (one-cycle strobe)
//   mem_rdata                     - memory read data, MEM_LAT cycles after mem_en
//   fsm_state                     - current FSM state (debug observation)
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                d_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          fsm_state
);

  localparam int BEW = DATA_W / 8;
  localparam int SW  = $clog2(MAX_STREAK + 1);
  localparam int TW  = $clog2(MEM_LAT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(MEM_LAT - 1);

  logic [1:0]        state;
  logic              owner;
  logic [SW-1:0]     streak;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [BEW-1:0]    cmd_be;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              tmr_zero;
  logic              grant_d;

  // Fetch only takes the port from a pending data request once the streak
  // of data grants made while it waited has hit the bound.
  assign grant_d = d_req && !(if_req && (streak == STREAK_MAX));

  mem_lat_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ISSUE),
    .load_val (TMR_LOAD),
    .dec      (state == ST_WAIT),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      streak    <= '0;
      cmd_addr  <= '0;
      cmd_we    <= 1'b0;
      cmd_be    <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_req || d_req) begin
            state <= ST_ISSUE;
            if (grant_d) begin
              owner     <= OWN_D;
              cmd_addr  <= d_addr;
              cmd_we    <= d_we;
              cmd_be    <= d_be;
              cmd_wdata <= d_wdata;
              streak    <= SW'(next_streak(int'(streak), if_req, MAX_STREAK));
            end else begin
              owner     <= OWN_IF;
              cmd_addr  <= if_addr;
              cmd_we    <= 1'b0;
              cmd_be    <= '1;
              cmd_wdata <= '0;
              streak    <= '0;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          // Timer reaching zero marks the cycle mem_rdata is valid.
          if (tmr_zero) begin
            if (!cmd_we) rdata_q <= mem_rdata;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ST_ISSUE);
  assign mem_we    = cmd_we;
  assign mem_be    = cmd_be;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  assign if_ready  = (state == ST_DONE) && (owner == OWN_IF);
  assign d_ready   = (state == ST_DONE) && (owner == OWN_D);
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;

  assign if_stall  = if_req & ~if_ready;
  assign d_stall   = d_req & ~d_ready;

  assign fsm_state = state;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified instruction/data memory between the fetch stage and the MEM stage of the 5-stage CPU. It serialises their accesses and sequences each access through a fixed-latency memory. It returns read data and per-requester stall signals to the pipeline. It sits between `CPU_top`'s fetch/MEM stages and the memory macro. Data accesses get priority, with a bounded-starvation guarantee for fetch.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte enables
- `MEM_LAT`, 2, cycles from `mem_en` to valid `mem_rdata`; legal range ≥1
- `MAX_STREAK`, 4, maximum consecutive data grants while fetch is waiting; legal range ≥1

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `if_req` in 1: fetch request, held until `if_ready`.
- `if_addr` in ADDR_W: fetch address, stable while `if_req`.
- `if_rdata` out DATA_W: fetch read data, valid with `if_ready`.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `if_stall` out 1: fetch stage must hold.
- `d_req` in 1: data request, held until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in DATA_W/8: store byte enables.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data, valid with `d_ready`.
- `d_ready` out 1: one-cycle completion pulse for data.
- `d_stall` out 1: MEM stage must hold.
- `mem_en` out 1: memory access strobe, one cycle per access.
- `mem_we` out 1: memory write.
- `mem_be` out DATA_W/8: memory byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid `MEM_LAT` cycles after `mem_en`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**, no request pending: stay in IDLE.
- **IDLE**, any request pending:
  - Arbitrate, latch the owner (IF or D), register the command, go to ISSUE.
  - Requests are sampled only in IDLE.
- **Arbitration rule**:
  - The data request wins by default.
  - Fetch wins if only `if_req` is high.
  - Fetch also wins if both are high and `streak == MAX_STREAK`.
- **Streak counter** (width `$clog2(MAX_STREAK+1)`):
  - Data grant with `if_req` high: increment, saturating at `MAX_STREAK`.
  - Data grant with `if_req` low: clear to 0.
  - Fetch grant: clear to 0.
- **ISSUE**:
  - `mem_en=1` for exactly this cycle.
  - `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` come from registers.
  - A fetch issues with `mem_we=0` and `mem_be=all 1s`.
  - Next state is WAIT and the latency timer loads `MEM_LAT-1`.
- **WAIT**:
  - Decrement the timer.
  - When the timer reaches 0 on a read, capture `mem_rdata` into `rdata_q` at the clock edge, then go to DONE.
  - A store does not capture; `rdata_q` is unchanged.
- **DONE**:
  - Pulse the owner's ready for one cycle, then go to IDLE.
  - `if_rdata` and `d_rdata` are both driven from `rdata_q`.
  - Each is meaningful only with its own ready.
- **Stall outputs** (combinational): `if_stall = if_req & ~if_ready`; `d_stall = d_req & ~d_ready`.
- **Request dropped mid-transaction** (protocol violation): the transaction completes anyway and the ready pulse is still issued.
- **Reset asserted in any state**:
  - Go to IDLE immediately.
  - Any in-flight access is abandoned.
  - A late `mem_rdata` return is ignored.
  - No ready pulse is produced.
- **Reset values**:
  - All outputs 0, apart from the combinational stall outputs below.
  - `rdata_q`, `streak`, owner and timer are 0.
  - Stall outputs follow `req` combinationally and are the only outputs not forced to 0.

## Timing
- Request seen in IDLE in cycle 0:
  - `mem_en` in cycle 1.
  - `mem_rdata` sampled at the end of cycle `1+MEM_LAT`.
  - Ready in cycle `2+MEM_LAT`.
  - IDLE in cycle `3+MEM_LAT`.
- With the default `MEM_LAT=2`: issue in cycle 1, ready in cycle 4.
- Back-to-back throughput: one access per `MEM_LAT+3` cycles.
- A requester may drop `req` or change address in the cycle after its ready pulse.
- A new request sampled in IDLE issues in the following cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - The state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3).
  - Owner encoding (OWN_IF=1'b0, OWN_D=1'b1).
  - Default `MEM_LAT`/`MAX_STREAK` constants.
- One natural sub-module is `mem_lat_timer`:
  - Loadable down-counter with a `zero` flag.
  - Asynchronous active-low reset.
- Arbitration, the streak counter and the FSM stay in `mem_port_arbiter`.

## Test plan
All scenarios use `MEM_LAT=2` and `MAX_STREAK=4` unless stated.
1. **Single fetch:** `if_req=1`, `if_addr=0x8` in cycle 0; memory returns 0x002081b3 in cycle 3 -> `mem_en=1`, `mem_addr=0x8`, `mem_we=0` in cycle 1; `if_ready=1` with `if_rdata=0x002081b3` in cycle 4; `if_stall=1` in cycles 0–3 and 0 in cycle 4.
2. **Simultaneous requests:** `if_req` and `d_req` (load at 0x40) both high in cycle 0 -> data issues in cycle 1 with `mem_addr=0x40`; `d_ready` in cycle 4; fetch issues in cycle 6; `if_ready` in cycle 9.
3. **Starvation bound:** `d_req` and `if_req` held continuously -> grants go D, D, D, D, IF, D…; the fifth `mem_en` carries `if_addr`.
4. **Store:** `d_we=1`, `d_be=4'b0011`, `d_addr=0x100`, `d_wdata=0xDEADBEEF` -> cycle 1 has `mem_we=1`, `mem_be=0011`, `mem_wdata=0xDEADBEEF`; `d_ready` in cycle 4; `rdata_q` unchanged.
5. **Reset mid-access:** `rst=0` during WAIT -> all outputs 0 asynchronously; memory data returned in cycle 3 is ignored; no ready pulse. After `rst=1` with `if_req` held, the fetch completes with `if_ready` 4 cycles after the first IDLE cycle.
6. **`MEM_LAT=1` build:** single fetch -> `mem_en` in cycle 1, `if_ready` in cycle 3.
